// File: rtl/nonce_work_feeder.sv
// -----------------------------------------------------------------------------
// nonce_work_feeder
//
// Work generator that feeds sha256_wrapper. It accepts one mining job, which is
// a precomputed midstate plus the 96-bit header tail. It then sweeps the nonce
// from NONCE_START to job_nonce_end in steps of NONCE_STEP and emits one padded
// 512-bit second block per nonce over a valid/ready handshake. It counts the
// blocks that are issued but not yet retired, and pulses exhausted once the job
// has been swept or aborted and every issued block has completed.
//
// Bit numbering: midstate and block2 are declared [N:0]. The consumer numbers
// them [0:N] MSB-first, so consumer bit 0 is our bit N.
//
// Parameters:
//   NONCE_START   first nonce issued for every job
//   NONCE_STEP    nonce increment, must be >= 1
//   MAX_INFLIGHT  cap on issued-but-unretired blocks, 1..255
//
// Configuration macro:
//   FEEDER_BYTESWAP_EN  defined: the nonce field of block2 is the byte-reversed
//                       counter (Bitcoin little-endian header encoding).
//                       undefined: the nonce field is the counter verbatim.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   job_valid      new job offered (taken only while job_ready)
//   job_ready      high in IDLE
//   job_midstate   midstate of header block 1
//   job_tail       {merkle_tail, ntime, nbits}, in header byte order
//   job_nonce_end  last nonce allowed (inclusive)
//   abort          stop issuing and drain the in-flight blocks
//   midstate       midstate to the hash core
//   block2         padded second block to the hash core
//   blk_valid      midstate/block2/blk_nonce are valid
//   blk_ready      consumer accepts the block this cycle
//   blk_nonce      raw nonce counter carried in block2
//   hash_done      one-cycle pulse per retired block
//   busy           feeder is not idle
//   exhausted      one-cycle pulse when the job is finished and drained
// -----------------------------------------------------------------------------
module nonce_work_feeder #(
    parameter logic [31:0] NONCE_START  = 32'h0,
    parameter logic [31:0] NONCE_STEP   = 32'h1,
    parameter int          MAX_INFLIGHT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_midstate,
    input  logic [95:0]  job_tail,
    input  logic [31:0]  job_nonce_end,
    input  logic         abort,
    output logic [255:0] midstate,
    output logic [511:0] block2,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [31:0]  blk_nonce,
    input  logic         hash_done,
    output logic         busy,
    output logic         exhausted
);

    // state    | meaning
    // ST_IDLE  | waiting for a job, job_ready high
    // ST_ISSUE | offering blocks while below the in-flight cap
    // ST_DRAIN | no more issuing, waiting for in-flight blocks to retire
    // ST_DONE  | one-cycle exhausted pulse
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] CAP = 8'(MAX_INFLIGHT);

    logic [1:0]   state;
    logic [31:0]  nonce;
    logic [31:0]  nonce_end;
    logic [95:0]  tail;
    logic [255:0] mid;
    logic [7:0]   inflight;
    // Keeps block2 at zero until the first job has been loaded. Without it,
    // the constant padding bits would show through right after reset.
    logic         loaded;

    logic         xfer;
    logic         retire;
    logic         last_nonce;
    logic [31:0]  nonce_field;

    assign blk_valid = (state == ST_ISSUE) && (inflight < CAP);
    assign xfer      = blk_valid && blk_ready;
    // A hash_done with nothing in flight is ignored so the count cannot underflow.
    assign retire    = hash_done && (inflight != 8'd0);
    // The distance to the end is compared with the step instead of adding the
    // step to the nonce, so the nonce never wraps past the 32-bit limit.
    assign last_nonce = (nonce_end - nonce) < NONCE_STEP;

`ifdef FEEDER_BYTESWAP_EN
    assign nonce_field = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
`else
    assign nonce_field = nonce;
`endif

    // Layout from the top: tail, nonce field, the 1 pad bit, zeros, then the
    // 64-bit length of the 80-byte header, 640 bits.
    assign block2    = loaded ? {tail, nonce_field, 1'b1, 319'd0, 64'd640} : '0;
    assign midstate  = mid;
    assign blk_nonce = nonce;
    assign job_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign exhausted = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            nonce     <= '0;
            nonce_end <= '0;
            tail      <= '0;
            mid       <= '0;
            inflight  <= '0;
            loaded    <= 1'b0;
        end else begin
            if (xfer && !retire) begin
                inflight <= inflight + 8'd1;
            end else if (!xfer && retire) begin
                inflight <= inflight - 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        mid       <= job_midstate;
                        tail      <= job_tail;
                        nonce_end <= job_nonce_end;
                        nonce     <= NONCE_START;
                        loaded    <= 1'b1;
                        state     <= (NONCE_START > job_nonce_end) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (xfer && !last_nonce) begin
                        nonce <= nonce + NONCE_STEP;
                    end
                    if (abort || (xfer && last_nonce)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (inflight == 8'd0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_work_feeder.sv
// -----------------------------------------------------------------------------
// tb_nonce_work_feeder
//
// Self-checking bench for nonce_work_feeder. It uses three instances:
//   u0  default parameters; runs directed and randomized jobs checked against
//       a queue-based reference model
//   u1  NONCE_START=0x12345678, MAX_INFLIGHT=2; exercises the block2 encoding
//       and the in-flight cap
//   u2  NONCE_START=0xFFFFFFF8, NONCE_STEP=4; exercises the end of the nonce
//       range without wrap, and a start that lies past the end
// Define FEEDER_BYTESWAP_EN for both the bench and the RTL to check the
// byte-swapped build.
// -----------------------------------------------------------------------------
module tb_nonce_work_feeder;

    localparam logic [31:0] START0 = 32'h0;
    localparam logic [31:0] STEP0  = 32'h1;
    localparam int          CAP0   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] jm;
    logic [95:0]  jt;
    logic [31:0]  je;

    logic         jv0, ab0, rdy0, hd0, jr0, v0, busy0, ex0;
    logic [255:0] ms0;
    logic [511:0] b2_0;
    logic [31:0]  n0;

    logic         jv1, ab1, rdy1, hd1, jr1, v1, busy1, ex1;
    logic [255:0] ms1;
    logic [511:0] b2_1;
    logic [31:0]  n1;

    logic         jv2, ab2, rdy2, hd2, jr2, v2, busy2, ex2;
    logic [255:0] ms2;
    logic [511:0] b2_2;
    logic [31:0]  n2;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model for u0: job phase, queue of nonces still to issue,
    // outstanding block count, and the captured job data.
    int           ph;      // 0 idle, 1 issuing, 2 draining, 3 done pulse
    int           infl;
    logic [31:0]  nq[$];
    logic [95:0]  m_tail;
    logic [255:0] m_ms;
    int           hd_mode; // 0 none, 1 two cycles after each transfer, 2 random
    logic [2:0]   hd_sr;

    always #5 clk = ~clk;

    nonce_work_feeder u0 (
        .clk(clk), .rst(rst), .job_valid(jv0), .job_ready(jr0),
        .job_midstate(jm), .job_tail(jt), .job_nonce_end(je), .abort(ab0),
        .midstate(ms0), .block2(b2_0), .blk_valid(v0), .blk_ready(rdy0),
        .blk_nonce(n0), .hash_done(hd0), .busy(busy0), .exhausted(ex0)
    );

    nonce_work_feeder #(.NONCE_START(32'h12345678), .NONCE_STEP(32'h1), .MAX_INFLIGHT(2)) u1 (
        .clk(clk), .rst(rst), .job_valid(jv1), .job_ready(jr1),
        .job_midstate(jm), .job_tail(jt), .job_nonce_end(je), .abort(ab1),
        .midstate(ms1), .block2(b2_1), .blk_valid(v1), .blk_ready(rdy1),
        .blk_nonce(n1), .hash_done(hd1), .busy(busy1), .exhausted(ex1)
    );

    nonce_work_feeder #(.NONCE_START(32'hFFFFFFF8), .NONCE_STEP(32'h4), .MAX_INFLIGHT(16)) u2 (
        .clk(clk), .rst(rst), .job_valid(jv2), .job_ready(jr2),
        .job_midstate(jm), .job_tail(jt), .job_nonce_end(je), .abort(ab2),
        .midstate(ms2), .block2(b2_2), .blk_valid(v2), .blk_ready(rdy2),
        .blk_nonce(n2), .hash_done(hd2), .busy(busy2), .exhausted(ex2)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected second block byte by byte, as the header bytes
    // are laid out in memory.
    function automatic logic [511:0] mk_block(input logic [95:0] t, input logic [31:0] n);
        logic [7:0]   b[64];
        logic [511:0] r;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 12; i++) b[i] = t[95-8*i -: 8];
`ifdef FEEDER_BYTESWAP_EN
        for (int i = 0; i < 4; i++) b[12+i] = n[8*i +: 8];
`else
        for (int i = 0; i < 4; i++) b[12+i] = n[31-8*i -: 8];
`endif
        b[16] = 8'h80;
        b[62] = 8'h02;
        b[63] = 8'h80;
        r = '0;
        for (int i = 0; i < 64; i++) r[511-8*i -: 8] = b[i];
        return r;
    endfunction

    task automatic new_job_data();
        for (int i = 0; i < 8; i++) jm[32*i +: 32] = $urandom;
        for (int i = 0; i < 3; i++) jt[32*i +: 32] = $urandom;
    endtask

    // One u0 cycle. Called just after a negedge: checks the outputs against
    // the model, drives the inputs for the next posedge, advances the model,
    // and then waits for the next negedge.
    task automatic cyc(input logic rdy, input logic ab, input logic jv, input logic [31:0] end_v);
        logic ev, xf, hd;
        longint k;
        ev = (ph == 1) && (infl < CAP0);
        chk("u0_job_ready", jr0, ph == 0);
        chk("u0_busy", busy0, ph != 0);
        chk("u0_exhausted", ex0, ph == 3);
        chk("u0_blk_valid", v0, ev);
        if (ev) begin
            chk("u0_blk_nonce", n0, nq[0]);
            chk("u0_block2", b2_0, mk_block(m_tail, nq[0]));
            chk("u0_midstate", ms0, m_ms);
        end
        case (hd_mode)
            1:       hd = hd_sr[0];
            2:       hd = ($urandom_range(0, 2) == 0);
            default: hd = 1'b0;
        endcase
        if (infl == 0) hd = 1'b0;
        xf = ev && rdy;
        hd_sr = hd_sr >> 1;
        if (xf) hd_sr[1] = 1'b1;
        rdy0 = rdy; ab0 = ab; jv0 = jv; hd0 = hd; je = end_v;
        if (jv) new_job_data();
        case (ph)
            0: if (jv) begin
                m_ms = jm;
                m_tail = jt;
                nq.delete();
                k = longint'(START0);
                while (k <= longint'(end_v)) begin
                    nq.push_back(32'(k));
                    k += longint'(STEP0);
                end
                ph = (nq.size() > 0) ? 1 : 2;
            end
            1: begin
                if (xf) void'(nq.pop_front());
                if (ab || (xf && nq.size() == 0)) ph = 2;
            end
            2: if (infl == 0) ph = 3;
            default: ph = 0;
        endcase
        if (xf && !hd) infl++;
        else if (!xf && hd) infl--;
        @(negedge clk);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        jv0 = 0; ab0 = 0; rdy0 = 0; hd0 = 0;
        @(negedge clk);
        rst = 1'b0;
        ph = 0; infl = 0; nq.delete(); hd_sr = '0;
        chk("rst_job_ready", jr0, 1'b1);
        chk("rst_blk_valid", v0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_exhausted", ex0, 1'b0);
        chk("rst_blk_nonce", n0, 32'h0);
        chk("rst_midstate", ms0, 256'h0);
        chk("rst_block2", b2_0, 512'h0);
    endtask

    initial begin
        int cnt, exc, xfc;
        logic [31:0] got[$];
        logic [95:0] t1;
        logic [255:0] m1;

        rst = 1'b1;
        jm = '0; jt = '0; je = '0;
        jv0 = 0; ab0 = 0; rdy0 = 0; hd0 = 0;
        jv1 = 0; ab1 = 0; rdy1 = 0; hd1 = 0;
        jv2 = 0; ab2 = 0; rdy2 = 0; hd2 = 0;
        ph = 0; infl = 0; hd_mode = 0; hd_sr = '0;
        repeat (3) @(negedge clk);
        chk("reset_u0_block2", b2_0, 512'h0);
        chk("reset_u0_ready", jr0, 1'b1);
        chk("reset_u1_valid", v1, 1'b0);
        chk("reset_u1_nonce", n1, 32'h0);
        chk("reset_u2_busy", busy2, 1'b0);
        chk("reset_u2_exhausted", ex2, 1'b0);
        rst = 1'b0;

        // u1: block2 encoding and the in-flight cap of 2.
        new_job_data();
        t1 = jt; m1 = jm;
        je = 32'h12345680; jv1 = 1;
        @(negedge clk);
        jv1 = 0;
        chk("u1_first_valid", v1, 1'b1);
        chk("u1_nonce", n1, 32'h12345678);
`ifdef FEEDER_BYTESWAP_EN
        chk("u1_nonce_field", b2_1[415:384], 32'h78563412);
`else
        chk("u1_nonce_field", b2_1[415:384], 32'h12345678);
`endif
        chk("u1_tail", b2_1[511:416], t1);
        chk("u1_pad_bit", b2_1[383], 1'b1);
        chk("u1_zero_fill", b2_1[382:64], 319'h0);
        chk("u1_length", b2_1[63:0], 64'h280);
        chk("u1_midstate", ms1, m1);
        rdy1 = 1; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (v1) cnt++;
            @(negedge clk);
        end
        chk("u1_cap_transfers", cnt, 2);
        chk("u1_valid_capped", v1, 1'b0);
        hd1 = 1;
        @(negedge clk);
        hd1 = 0; rdy1 = 0;
        chk("u1_valid_after_done", v1, 1'b1);
        chk("u1_next_nonce", n1, 32'h1234567A);
        ab1 = 1;
        @(negedge clk);
        ab1 = 0;
        chk("u1_abort_drops_valid", v1, 1'b0);

        // u2: no wrap at the top of the nonce range.
        je = 32'hFFFFFFFE; jv2 = 1; rdy2 = 1;
        @(negedge clk);
        jv2 = 0;
        for (int i = 0; i < 8; i++) begin
            if (v2) got.push_back(n2);
            @(negedge clk);
        end
        chk("u2_issue_count", got.size(), 2);
        while (got.size() < 2) got.push_back(32'h0);
        chk("u2_nonce_a", got[0], 32'hFFFFFFF8);
        chk("u2_nonce_b", got[1], 32'hFFFFFFFC);
        chk("u2_draining_busy", busy2, 1'b1);
        chk("u2_no_exhaust_yet", ex2, 1'b0);
        hd2 = 1;
        @(negedge clk);
        @(negedge clk);
        hd2 = 0; exc = 0;
        for (int i = 0; i < 5; i++) begin
            if (ex2) exc++;
            @(negedge clk);
        end
        chk("u2_exhaust_once", exc, 1);
        chk("u2_ready_again", jr2, 1'b1);
        // A start past the end issues nothing.
        je = 32'h10; jv2 = 1;
        @(negedge clk);
        jv2 = 0;
        chk("u2_skip_valid", v2, 1'b0);
        exc = 0; xfc = 0;
        for (int i = 0; i < 5; i++) begin
            if (ex2) exc++;
            if (v2) xfc++;
            @(negedge clk);
        end
        chk("u2_skip_exhaust", exc, 1);
        chk("u2_skip_no_issue", xfc, 0);

        do_rst();

        // u0: end=3 with hash_done two cycles after each transfer.
        hd_mode = 1;
        cyc(1, 0, 1, 32'd3);
        exc = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 0, 32'd3);
            if (ex0) exc++;
        end
        chk("u0_basic_exhaust_once", exc, 1);

        // Stall for 5 cycles, then one transfer.
        hd_mode = 0;
        cyc(0, 0, 1, 32'd10);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'd10);
        cyc(1, 0, 0, 32'd10);
        chk("u0_after_stall_nonce", n0, 32'd1);
        // Abort after 3 transfers, then drain through 3 hash_done pulses.
        cyc(1, 0, 0, 32'd10);
        cyc(1, 0, 0, 32'd10);
        cyc(0, 1, 0, 32'd10);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'd10);
        chk("u0_abort_holds_drain", busy0, 1'b1);
        hd_mode = 2;
        for (int i = 0; i < 60 && ph != 0; i++) cyc(0, 0, 0, 32'd10);
        cyc(0, 0, 0, 32'd10);
        chk("u0_abort_drained", jr0, 1'b1);

        // Randomized jobs: random ready, hash_done, abort and stray job_valid.
        for (int j = 0; j < 8; j++) begin
            cyc(1'($urandom_range(0, 1)), 0, 1, 32'($urandom_range(0, 15)));
            for (int i = 0; i < 400 && ph != 0; i++)
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
                    1'($urandom_range(0, 9) == 0), 32'($urandom_range(0, 15)));
            chk("u0_random_job_done", jr0, 1'b1);
        end

        // Reset in the middle of ISSUE.
        hd_mode = 0;
        cyc(1, 0, 1, 32'd15);
        cyc(1, 0, 0, 32'd15);
        cyc(1, 0, 0, 32'd15);
        do_rst();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
